transmit_engine: RTL and testbench

UART transmit engine for the UART/TSI subsystem. It accepts a byte from the processor output port on a `write0` strobe and serialises it LSB-first on `TX`. The bit period is set by `baud`; `EIGHT`, `PEN` and `OHEL` select the frame format. `TXRDY` tells the processor when a new byte may be written.

---
 rtl/transmit_engine.sv | 124 ++++++++++++
 tb/tb_transmit_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/transmit_engine.sv
// transmit_engine
//   UART transmit engine. A byte written on write0 (while TXRDY is high) is
//   framed as start bit, seven data bits, then two format-dependent bits
//   (bit9/bit10) and shifted out LSB-first on TX. Each bit lasts baud clocks.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   write0   in   one-cycle write strobe
//   out_port in   [7:0]  byte to transmit
//   baud     in   [18:0] bit period in clk cycles (0 behaves as 1)
//   EIGHT    in   1 = 8 data bits, 0 = 7 data bits
//   PEN      in   parity enable
//   OHEL     in   parity sense, 1 = odd, 0 = even
//   TXRDY    out  high when idle and able to accept a write
//   TX       out  serial line, idle high
module transmit_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        write0,
    input  logic [7:0]  out_port,
    input  logic [18:0] baud,
    input  logic        EIGHT,
    input  logic        PEN,
    input  logic        OHEL,
    output logic        TXRDY,
    output logic        TX
);

    logic        doit;       // frame in progress
    logic        load;       // one cycle after an accepted write
    logic [7:0]  ld;         // latched byte
    logic [10:0] shifter;    // bit 0 drives TX
    logic [3:0]  bit_cnt;
    logic [18:0] bt_cnt;

    logic [18:0] period_m1;
    logic        btu;
    logic        done;
    logic        par7;
    logic        par8;
    logic        bit9;
    logic        bit10;

    // A zero bit period runs at one bit per clock.
    always_comb begin
        period_m1 = '0;
        if (baud != '0)
            period_m1 = baud - 19'd1;
    end

    // The load cycle clears the counters, so no bit-time tick may fire in it.
    always_comb begin
        btu  = doit & ~load & (bt_cnt == period_m1);
        // 11th tick: the frame ends on the same edge that shifts out bit10.
        done = btu & (bit_cnt == 4'd10);
    end

    always_comb begin
        par7  = OHEL ? ~^ld[6:0] : ^ld[6:0];
        par8  = OHEL ? ~^ld[7:0] : ^ld[7:0];
        bit9  = 1'b1;
        bit10 = 1'b1;
        unique case ({EIGHT, PEN})
            2'b00: begin bit10 = 1'b1; bit9 = 1'b1;  end
            2'b01: begin bit10 = 1'b1; bit9 = par7;  end
            2'b10: begin bit10 = 1'b1; bit9 = ld[7]; end
            2'b11: begin bit10 = par8; bit9 = ld[7]; end
            default: begin bit10 = 1'b1; bit9 = 1'b1; end
        endcase
    end

    // Write acceptance and frame-in-progress control.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            TXRDY <= 1'b1;
            doit  <= 1'b0;
            load  <= 1'b0;
            ld    <= '0;
        end else begin
            load <= write0 & TXRDY;
            if (write0 && TXRDY) begin
                ld    <= out_port;
                TXRDY <= 1'b0;
                doit  <= 1'b1;
            end else if (done) begin
                TXRDY <= 1'b1;
                doit  <= 1'b0;
            end
        end
    end

    // Bit-time and bit counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bt_cnt  <= '0;
            bit_cnt <= '0;
        end else if (load || done) begin
            bt_cnt  <= '0;
            bit_cnt <= '0;
        end else if (doit) begin
            if (btu) begin
                bt_cnt  <= '0;
                bit_cnt <= bit_cnt + 4'd1;
            end else begin
                bt_cnt  <= bt_cnt + 19'd1;
            end
        end
    end

    // Shift register: the leading 1 gives one idle bit period before start,
    // and the 1s shifted in at the top form the stop bit and idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            shifter <= '1;
        else if (load)
            shifter <= {bit10, bit9, ld[6:0], 1'b0, 1'b1};
        else if (btu)
            shifter <= {1'b1, shifter[10:1]};
    end

    always_comb TX = shifter[0];

endmodule

// File: tb/tb_transmit_engine.sv
module tb_transmit_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        write0;
    logic [7:0]  out_port;
    logic [18:0] baud;
    logic        EIGHT;
    logic        PEN;
    logic        OHEL;
    logic        TXRDY;
    logic        TX;

    int total = 0;
    int bad   = 0;

    // Expected frame: r[0] = start bit, r[1..7] = ld[0..6], r[8] = bit9, r[9] = bit10.
    typedef struct {
        logic [9:0] bits;
        int         k;
        bit         aborted;
    } exp_t;

    exp_t sb[$];

    transmit_engine dut (
        .clk      (clk),
        .reset    (reset),
        .write0   (write0),
        .out_port (out_port),
        .baud     (baud),
        .EIGHT    (EIGHT),
        .PEN      (PEN),
        .OHEL     (OHEL),
        .TXRDY    (TXRDY),
        .TX       (TX)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [18:0] b, input logic e, input logic p, input logic o);
        baud  = b;
        EIGHT = e;
        PEN   = p;
        OHEL  = o;
    endtask

    task automatic push(input logic [9:0] bits, input int k, input bit ab);
        exp_t e;
        e.bits    = bits;
        e.k       = k;
        e.aborted = ab;
        sb.push_back(e);
    endtask

    task automatic do_write(input logic [7:0] d);
        @(negedge clk);
        out_port = d;
        write0   = 1'b1;
        @(negedge clk);
        write0   = 1'b0;
        chk("txrdy_fall", TXRDY, 1'b0);
    endtask

    // Counts clocks from the write edge until TXRDY returns; optionally
    // issues a stray write and a config change mid-frame.
    task automatic wait_ready(input int exp_cyc, input bit intrude);
        int cnt = 0;
        while (!TXRDY && cnt < 20000) begin
            @(negedge clk);
            cnt++;
            if (intrude) begin
                if (cnt == 500) begin
                    out_port = 8'hAA;
                    write0   = 1'b1;
                end
                if (cnt == 501)
                    write0 = 1'b0;
                if (cnt == 600) begin
                    EIGHT = 1'b0;
                    PEN   = 1'b1;
                    OHEL  = 1'b1;
                end
            end
        end
        chk("txrdy_rise_cycles", cnt, exp_cyc);
    endtask

    // Monitor: detects a start bit, samples every clock of each bit period,
    // and compares the mid-bit values against the scoreboard.
    initial begin : monitor
        exp_t       e;
        logic [9:0] got;
        logic       first;
        int         glitches;
        bit         ab;
        forever begin
            @(negedge clk);
            if (TX === 1'b0 && reset === 1'b0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                    while (TX === 1'b0) @(negedge clk);
                end else begin
                    e        = sb.pop_front();
                    got      = '0;
                    glitches = 0;
                    ab       = 1'b0;
                    first    = 1'b0;
                    for (int i = 0; i < 10 && !ab; i++) begin
                        for (int c = 0; c < e.k; c++) begin
                            if (!(i == 0 && c == 0))
                                @(negedge clk);
                            if (reset) begin
                                ab = 1'b1;
                                break;
                            end
                            if (c == 0)
                                first = TX;
                            else if (TX !== first)
                                glitches++;
                            if (c == e.k / 2)
                                got[i] = TX;
                        end
                    end
                    chk("frame_aborted", {31'd0, ab}, {31'd0, e.aborted});
                    if (!ab && !e.aborted) begin
                        chk("frame_bits", {22'd0, got}, {22'd0, e.bits});
                        chk("frame_glitches", glitches, 0);
                    end
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        write0   = 1'b0;
        out_port = 8'h00;
        set_cfg(19'd109, 1'b1, 1'b1, 1'b1);

        // Reset state
        #100;
        chk("reset_txrdy", TXRDY, 1'b1);
        chk("reset_tx", TX, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_txrdy", TXRDY, 1'b1);
        chk("idle_tx", TX, 1'b1);

        // 8 data bits, odd parity, 0x07: d7=0, parity=0
        push(10'h00E, 109, 1'b0);
        do_write(8'h07);
        wait_ready(1200, 1'b0);

        // Even parity: parity becomes 1
        set_cfg(19'd109, 1'b1, 1'b1, 1'b0);
        push(10'h20E, 109, 1'b0);
        do_write(8'h07);
        wait_ready(1200, 1'b0);

        // 7 data bits, no parity, 0xFF
        set_cfg(19'd109, 1'b0, 1'b0, 1'b0);
        push(10'h3FE, 109, 1'b0);
        do_write(8'hFF);
        wait_ready(1200, 1'b0);

        // Stray write and config change mid-frame: 0x55, 8N, both ignored
        set_cfg(19'd109, 1'b1, 1'b0, 1'b0);
        push(10'h2AA, 109, 1'b0);
        do_write(8'h55);
        wait_ready(1200, 1'b1);
        repeat (300) @(negedge clk);
        chk("stray_write_txrdy", TXRDY, 1'b1);
        chk("stray_write_tx", TX, 1'b1);

        // 7 data bits, even parity, 0x35 -> parity 0
        set_cfg(19'd3, 1'b0, 1'b1, 1'b0);
        push(10'h26A, 3, 1'b0);
        do_write(8'h35);
        wait_ready(34, 1'b0);

        // baud=0 runs as 1; write coinciding with done is ignored
        set_cfg(19'd0, 1'b1, 1'b1, 1'b1);
        push(10'h100, 1, 1'b0);
        do_write(8'h80);
        repeat (11) @(negedge clk);
        chk("baud0_busy_before_done", TXRDY, 1'b0);
        out_port = 8'h55;
        write0   = 1'b1;
        @(negedge clk);
        write0   = 1'b0;
        chk("baud0_txrdy_at_12", TXRDY, 1'b1);
        repeat (30) @(negedge clk);
        chk("done_write_ignored_txrdy", TXRDY, 1'b1);
        chk("done_write_ignored_tx", TX, 1'b1);

        // Reset during the 5th bit aborts the frame immediately
        set_cfg(19'd109, 1'b1, 1'b1, 1'b1);
        push(10'h00E, 109, 1'b1);
        do_write(8'h07);
        repeat (1 + 4 * 109 + 50 - 1) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midframe_reset_tx", TX, 1'b1);
        chk("midframe_reset_txrdy", TXRDY, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push(10'h00E, 109, 1'b0);
        do_write(8'h07);
        wait_ready(1200, 1'b0);

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
